// File: rtl/lfsr_signature_compactor_if.sv
// Bus between the BIST signature compactor and the pattern-LFSR / controller side.
// master drives start and pat_in; slave (the compactor) drives the LFSR controls and status.
interface lfsr_signature_compactor_if;
   logic       start;
   logic [7:0] pat_in;
   logic       lfsr_enable;
   logic       lfsr_reset;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] signature;

   modport master (
      output start, pat_in,
      input  lfsr_enable, lfsr_reset, busy, done, pass, signature
   );

   modport slave (
      input  start, pat_in,
      output lfsr_enable, lfsr_reset, busy, done, pass, signature
   );
endinterface

// File: rtl/lfsr_signature_compactor.sv
// BIST signature compactor: resets and steps the upstream 8-bit pattern LFSR,
// folds each pattern into a Galois MISR (x^8+x^6+x^5+x^4+1) and compares against GOLDEN.
module lfsr_signature_compactor #(
   parameter int unsigned NUM_PATTERNS = 16,
   parameter logic [7:0]  SEED         = 8'h00,
   parameter logic [7:0]  GOLDEN       = 8'h00
) (
   input  logic                          clk,
   input  logic                          reset,
   lfsr_signature_compactor_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN,
      DONE
   } state_t;

   // Terminal count; the wrapped value for NUM_PATTERNS==0 is never compared since RUN is skipped.
   localparam logic [15:0] LAST = 16'(NUM_PATTERNS - 1);

   state_t      state;
   logic [7:0]  signature;
   logic [15:0] count;
   logic        pass_q;
   logic [7:0]  misr_next;

   always_comb begin
      misr_next = {signature[6:0], 1'b0} ^ (signature[7] ? 8'h71 : 8'h00) ^ bus.pat_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         signature <= '0;
         count     <= '0;
         pass_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state <= INIT;
               end
            end
            INIT: begin
               signature <= SEED;
               count     <= '0;
               if (NUM_PATTERNS == 0) begin
                  state  <= DONE;
                  pass_q <= (SEED == GOLDEN);
               end else begin
                  state  <= RUN;
                  pass_q <= 1'b0;
               end
            end
            RUN: begin
               signature <= misr_next;
               count     <= count + 16'd1;
               if (count == LAST) begin
                  state  <= DONE;
                  pass_q <= (misr_next == GOLDEN);
               end
            end
            DONE: begin
               if (bus.start) begin
                  state  <= INIT;
                  pass_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.lfsr_reset  = (state == INIT);
   assign bus.lfsr_enable = (state == RUN);
   assign bus.busy        = (state == INIT) || (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.pass        = pass_q;
   assign bus.signature   = signature;

endmodule

// File: tb/tb_lfsr_signature_compactor.sv
// Scoreboard bench for lfsr_signature_compactor: three parameterisations, random and LFSR-driven runs,
// reference signatures from GF(2^8) polynomial arithmetic.
module tb_lfsr_signature_compactor;

   localparam int unsigned NP [3] = '{9, 16, 0};
   localparam logic [7:0]  SD [3] = '{8'h00, 8'h3C, 8'h5A};
   localparam logic [7:0]  GD [3] = '{8'h8E, 8'h00, 8'h5A};

   typedef struct {
      int         dut;
      logic [7:0] sig;
      logic       pass;
      int         done_cyc;
      int         n;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       use_lfsr;
   logic [2:0] start_v;
   logic [7:0] pat_drv [3];
   logic [2:0] done_v, busy_v, pass_v, len_v, lrst_v;
   logic [7:0] sig_v [3];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   for (genvar i = 0; i < 3; i++) begin : g_dut
      lfsr_signature_compactor_if ifc ();
      logic [7:0] lq;

      lfsr_signature_compactor #(
         .NUM_PATTERNS(NP[i]),
         .SEED        (SD[i]),
         .GOLDEN      (GD[i])
      ) dut (
         .clk  (clk),
         .reset(reset),
         .bus  (ifc.slave)
      );

      // Upstream XNOR pattern LFSR: 00 -> 01 -> 03 -> 07 -> 0F -> 1E -> 3C ...
      always @(posedge clk) begin
         if (ifc.lfsr_reset)       lq <= 8'h00;
         else if (ifc.lfsr_enable) lq <= {lq[6:0], ~(lq[7] ^ lq[6] ^ lq[5] ^ lq[3])};
      end

      assign ifc.start  = start_v[i];
      assign ifc.pat_in = use_lfsr ? lq : pat_drv[i];
      assign done_v[i]  = ifc.done;
      assign busy_v[i]  = ifc.busy;
      assign pass_v[i]  = ifc.pass;
      assign len_v[i]   = ifc.lfsr_enable;
      assign lrst_v[i]  = ifc.lfsr_reset;
      assign sig_v[i]   = ifc.signature;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Carry-less product reduced modulo x^8+x^6+x^5+x^4+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h0171 << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] xpow(input int j);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < j; i++) r = gf_mul(r, 8'h02);
      return r;
   endfunction

   // Final signature = seed*x^N + sum p_k*x^(N-1-k) in GF(2^8).
   function automatic logic [7:0] ref_sig(input logic [7:0] seed, input logic [7:0] p[$], input int n);
      logic [7:0] s;
      s = gf_mul(seed, xpow(n));
      for (int k = 0; k < n; k++) s = s ^ gf_mul(p[k], xpow(n - 1 - k));
      return s;
   endfunction

   function automatic logic [7:0] lfsr_model(input int k);
      logic [7:0] q;
      q = 8'h00;
      for (int i = 0; i < k; i++) q = {q[6:0], ~(q[7] ^ q[6] ^ q[5] ^ q[3])};
      return q;
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
      end
   endtask

   task automatic monitor();
      logic [2:0] done_prev;
      logic [2:0] rst_prev;
      int         rst_cnt [3];
      int         en_cnt  [3];
      exp_t       e;
      done_prev = '0;
      rst_prev  = '0;
      for (int d = 0; d < 3; d++) begin
         rst_cnt[d] = 0;
         en_cnt[d]  = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (lrst_v[d]) begin
               if (!rst_prev[d]) rst_cnt[d] = 0;
               rst_cnt[d]++;
               en_cnt[d] = 0;
            end
            if (len_v[d]) en_cnt[d]++;
            rst_prev[d] = lrst_v[d];
            if (done_v[d] && !done_prev[d]) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", d, 32'(done_v[d]), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("done_dut",       d, d,          e.dut);
                  chk("signature",      d, sig_v[d],   e.sig);
                  chk("pass",           d, pass_v[d],  e.pass);
                  chk("done_latency",   d, cyc,        e.done_cyc);
                  chk("enable_cycles",  d, en_cnt[d],  e.n);
                  chk("lfsr_reset_len", d, rst_cnt[d], 1);
               end
            end
            done_prev[d] = done_v[d];
         end
      end
   endtask

   // One run on DUT d; restart_at / reset_at pick a RUN cycle for a stray start or an abort (-1 = none).
   task automatic run(input int d, input bit lfsr_mode, input bit const_mode,
                      input int restart_at, input int reset_at);
      logic [7:0] pats[$];
      logic [7:0] es;
      int         n;
      n = int'(NP[d]);
      for (int k = 0; k < n; k++) begin
         if (lfsr_mode)       pats.push_back(lfsr_model(k));
         else if (const_mode) pats.push_back(8'h01);
         else                 pats.push_back(8'($urandom_range(0, 255)));
      end
      es = ref_sig(SD[d], pats, n);
      if (reset_at < 0) sb.push_back('{d, es, (es == GD[d]), cyc + n + 2, n});
      use_lfsr   = lfsr_mode;
      pat_drv[d] = (n > 0) ? pats[0] : 8'h00;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      chk("init_lfsr_reset", d, lrst_v[d], 1);
      chk("init_busy",       d, busy_v[d], 1);
      chk("init_pass",       d, pass_v[d], 0);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         pat_drv[d] = pats[k];
         if (k == restart_at)     start_v[d] = 1'b1;
         if (k == restart_at + 1) start_v[d] = 1'b0;
         if (k == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("abort_signature", d, sig_v[d],  8'h00);
            chk("abort_enable",    d, len_v[d],  0);
            chk("abort_busy",      d, busy_v[d], 0);
            chk("abort_done",      d, done_v[d], 0);
            repeat (3) @(negedge clk);
            return;
         end
      end
      start_v[d] = 1'b0;
      for (int t = 0; t < 8 && !done_v[d]; t++) @(negedge clk);
      chk("done_timeout", d, done_v[d], 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      use_lfsr = 1'b0;
      start_v  = '0;
      for (int d = 0; d < 3; d++) pat_drv[d] = 8'h00;
      fork
         monitor();
      join_none

      // Reset with start held high: nothing may be honoured.
      @(negedge clk);
      start_v = '1;
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      start_v = '0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_signature",  d, sig_v[d],  8'h00);
         chk("rst_busy",       d, busy_v[d], 0);
         chk("rst_done",       d, done_v[d], 0);
         chk("rst_pass",       d, pass_v[d], 0);
         chk("rst_enable",     d, len_v[d],  0);
         chk("rst_lfsr_reset", d, lrst_v[d], 0);
      end

      run(0, 1'b0, 1'b1, -1, -1);
      for (int r = 0; r < 3; r++) run(0, 1'b0, 1'b0, -1, -1);
      run(0, 1'b0, 1'b1, 5, -1);

      run(1, 1'b1, 1'b0, -1, -1);
      run(1, 1'b1, 1'b0, -1, -1);
      run(1, 1'b0, 1'b1, -1, -1);
      for (int r = 0; r < 6; r++) run(1, 1'b0, 1'b0, -1, -1);

      run(0, 1'b0, 1'b1, -1, 4);
      run(0, 1'b0, 1'b1, -1, -1);
      run(1, 1'b1, 1'b0, -1, 7);
      run(1, 1'b1, 1'b0, -1, -1);

      run(2, 1'b0, 1'b0, -1, -1);
      run(2, 1'b0, 1'b0, -1, -1);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 0, sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
